// File: rtl/fetch_prefetch_stage.sv
// Purpose: instruction fetch with one-outstanding memory requests and a DEPTH-entry {pc,instr} prefetch FIFO.
// Latency: a word reaches IF/ID one cycle after its memory response (the FIFO is never bypassed).
// Backpressure: stall holds IF/ID and stops pops; requests stop while the FIFO would overflow.
//
// Ports:
//   clk, rst                  clock and async active-high reset
//   stall                     ID not ready: hold IF/ID, no FIFO pop
//   b_taken, b_pc             redirect: flush FIFO and IF/ID, restart fetch at b_pc
//   imem_req, imem_addr       combinational request to instruction memory (addr = pc)
//   imem_rvalid, imem_rdata   memory response, at least one cycle after the request
//   pc                        next address to request
//   if_id_pc/instr/valid      IF/ID register contents
//   fifo_count                prefetch FIFO occupancy
module fetch_prefetch_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       b_taken,
  input  logic [XLEN-1:0]            b_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_rvalid,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic [XLEN-1:0]            pc,
  output logic [XLEN-1:0]            if_id_pc,
  output logic [XLEN-1:0]            if_id_instr,
  output logic                       if_id_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [XLEN-1:0] pend_pc;     // pc of the request currently outstanding
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic [CW:0]     occ_after;   // occupancy once this cycle's push/pop land

  assign fifo_empty = (fifo_count == '0);
  assign pop        = !stall && !b_taken && !fifo_empty;
  assign push       = (state == WAIT) && imem_rvalid && !b_taken;
  assign occ_after  = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(pop);
  assign imem_addr  = pc;

  // A new request needs a guaranteed free slot for its eventual response.
  // From WAIT the slot check accounts for the word being pushed right now.
  always_comb begin
    imem_req = 1'b0;
    if (!b_taken) begin
      case (state)
        IDLE:    imem_req = ({1'b0, fifo_count} < DEPTH_X);
        WAIT:    imem_req = imem_rvalid && (occ_after < DEPTH_X);
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (imem_req) state_nxt = WAIT;
      end
      WAIT: begin
        if (b_taken) begin
          // Response still in flight after a redirect must be swallowed.
          state_nxt = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          state_nxt = imem_req ? WAIT : IDLE;
        end
      end
      DROP: begin
        // Leave on the response even if another redirect arrives, otherwise
        // the FSM would wait for a word that never comes.
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= BOOT_ADDRESS;
      pend_pc     <= '0;
      head        <= '0;
      tail        <= '0;
      fifo_count  <= '0;
      if_id_pc    <= '0;
      if_id_instr <= BUBBLE_INSTR;
      if_id_valid <= 1'b0;
    end else if (b_taken) begin
      // Redirect overrides stall: stale IF/ID contents must not reach ID.
      pc          <= b_pc;
      head        <= '0;
      tail        <= '0;
      fifo_count  <= '0;
      if_id_pc    <= '0;
      if_id_instr <= BUBBLE_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      if (imem_req) begin
        pc      <= pc + XLEN'(4);
        pend_pc <= pc;
      end
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (!stall) begin
        if (!fifo_empty) begin
          if_id_pc    <= fifo_pc[head];
          if_id_instr <= fifo_instr[head];
          if_id_valid <= 1'b1;
        end else begin
          if_id_pc    <= '0;
          if_id_instr <= BUBBLE_INSTR;
          if_id_valid <= 1'b0;
        end
      end
    end
  end

  // Storage needs no reset: entries are only read when fifo_count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]    <= pend_pc;
      fifo_instr[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
module tb_fetch_prefetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, b_taken;
  logic [31:0] b_pc;

  logic        req4, rvalid4, ifv4;
  logic [31:0] addr4, rdata4, pc4, ifpc4, ifin4;
  logic [2:0]  cnt4;

  logic        req8, rvalid8, ifv8;
  logic [31:0] addr8, rdata8, pc8, ifpc8, ifin8;
  logic [3:0]  cnt8;

  fetch_prefetch_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_pc(b_pc),
    .imem_req(req4), .imem_addr(addr4), .imem_rvalid(rvalid4), .imem_rdata(rdata4),
    .pc(pc4), .if_id_pc(ifpc4), .if_id_instr(ifin4), .if_id_valid(ifv4),
    .fifo_count(cnt4)
  );

  fetch_prefetch_stage #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_pc(b_pc),
    .imem_req(req8), .imem_addr(addr8), .imem_rvalid(rvalid8), .imem_rdata(rdata8),
    .pc(pc8), .if_id_pc(ifpc8), .if_id_instr(ifin8), .if_id_valid(ifv8),
    .fifo_count(cnt8)
  );

  int checks = 0;
  int errors = 0;

  // Memory models: respond lat cycles after a request with instr = ~addr.
  int          lat4 = 1;
  int          mcnt4 = 0, mcnt8 = 0;
  logic        busy4 = 1'b0, busy8 = 1'b0;
  logic [31:0] maddr4 = '0, maddr8 = '0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample requests, clock, then update memory responses.
  task automatic tick();
    logic        s_req4, s_req8;
    logic [31:0] s_a4, s_a8;
    #1;
    s_req4 = req4 & !rst;
    s_req8 = req8 & !rst;
    s_a4   = addr4;
    s_a8   = addr8;
    @(posedge clk);
    @(negedge clk);
    rvalid4 = 1'b0;
    rvalid8 = 1'b0;
    if (s_req4) begin busy4 = 1'b1; mcnt4 = lat4; maddr4 = s_a4; end
    if (s_req8) begin busy8 = 1'b1; mcnt8 = 1;    maddr8 = s_a8; end
    if (busy4) begin
      mcnt4--;
      if (mcnt4 == 0) begin busy4 = 1'b0; rvalid4 = 1'b1; rdata4 = ~maddr4; end
    end
    if (busy8) begin
      mcnt8--;
      if (mcnt8 == 0) begin busy8 = 1'b0; rvalid8 = 1'b1; rdata8 = ~maddr8; end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; b_taken = 1'b0; b_pc = '0;
    rvalid4 = 1'b0; rdata4 = '0; rvalid8 = 1'b0; rdata8 = '0;
    tick(); tick();

    // Reset state
    chk("rst_pc", pc4, 32'h0);
    chk("rst_ifpc", ifpc4, 32'h0);
    chk("rst_instr", ifin4, 32'h13);
    chk("rst_valid", {31'b0, ifv4}, 32'h0);
    chk("rst_cnt", {29'b0, cnt4}, 32'h0);
    chk("rst_cnt8", {28'b0, cnt8}, 32'h0);

    // 1: back-to-back streaming with one-cycle memory latency
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t1_req", {31'b0, req4}, 32'h1);
      chk("t1_addr", addr4, 32'(4 * k));
      tick();
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        chk("t1_valid", {31'b0, ifv4}, 32'h1);
        chk("t1_ifpc", ifpc4, exp_pc);
        chk("t1_instr", ifin4, ~exp_pc);
      end else begin
        chk("t1_bubble", {31'b0, ifv4}, 32'h0);
      end
    end

    // 2: stall fills the FIFO, IF/ID frozen; release drains it in order
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hold_pc", ifpc4, 32'd20);
      chk("t2_hold_v", {31'b0, ifv4}, 32'h1);
      if (i == 0) chk("t2_cnt_first", {29'b0, cnt4}, 32'd2);
    end
    chk("t2_cnt_full", {29'b0, cnt4}, 32'd4);
    chk("t2_pc", pc4, 32'd40);
    chk("t2_noreq", {31'b0, req4}, 32'h0);
    chk("t2_cnt8_full", {28'b0, cnt8}, 32'd8);
    chk("t2_pc8", pc8, 32'd56);
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = 32'(24 + 4 * i);
      chk("t2_drain_pc", ifpc4, exp_pc);
      chk("t2_drain_instr", ifin4, ~exp_pc);
      chk("t2_drain_v", {31'b0, ifv4}, 32'h1);
      if (i == 0) begin
        chk("t2_cnt_pop", {29'b0, cnt4}, 32'd3);
        chk("t2_cnt8_pop", {28'b0, cnt8}, 32'd7);
        chk("t2_ifpc8", ifpc8, 32'd24);
      end
    end

    // 4: redirect coincides with a response and a stall
    stall = 1'b1; b_taken = 1'b1; b_pc = 32'h200;
    #1;
    chk("t4_noreq", {31'b0, req4}, 32'h0);
    tick();
    chk("t4_valid", {31'b0, ifv4}, 32'h0);
    chk("t4_ifpc", ifpc4, 32'h0);
    chk("t4_instr", ifin4, 32'h13);
    chk("t4_cnt", {29'b0, cnt4}, 32'h0);
    chk("t4_pc", pc4, 32'h200);
    b_taken = 1'b0; stall = 1'b0;
    #1;
    chk("t4_req", {31'b0, req4}, 32'h1);
    chk("t4_addr", addr4, 32'h200);

    // 3: redirect while a slow response is outstanding
    lat4 = 3;
    tick();
    b_taken = 1'b1; b_pc = 32'h100;
    tick();
    b_taken = 1'b0;
    #1;
    chk("t3_drop_noreq", {31'b0, req4}, 32'h0);
    chk("t3_pc", pc4, 32'h100);
    tick();
    chk("t3_drop_rv_noreq", {31'b0, req4}, 32'h0);
    chk("t3_valid", {31'b0, ifv4}, 32'h0);
    lat4 = 1;
    tick();
    chk("t3_req", {31'b0, req4}, 32'h1);
    chk("t3_addr", addr4, 32'h100);
    chk("t3_cnt", {29'b0, cnt4}, 32'h0);
    chk("t3_valid2", {31'b0, ifv4}, 32'h0);
    tick(); tick();
    lat4 = 2;
    tick();
    chk("t3_ifpc", ifpc4, 32'h100);
    chk("t3_instr", ifin4, ~32'h100);
    chk("t3_v", {31'b0, ifv4}, 32'h1);

    // 5: reset while a request is outstanding; stale response ignored
    rst = 1'b1;
    #1;
    chk("t5_pc", pc4, 32'h0);
    chk("t5_cnt", {29'b0, cnt4}, 32'h0);
    chk("t5_valid", {31'b0, ifv4}, 32'h0);
    chk("t5_ifpc", ifpc4, 32'h0);
    chk("t5_instr", ifin4, 32'h13);
    tick();
    rst = 1'b0; lat4 = 3;
    #1;
    chk("t5_req", {31'b0, req4}, 32'h1);
    chk("t5_addr", addr4, 32'h0);
    tick();
    chk("t5_stale_cnt", {29'b0, cnt4}, 32'h0);
    chk("t5_stale_v", {31'b0, ifv4}, 32'h0);
    chk("t5_pc_next", pc4, 32'h4);
    tick();
    chk("t5_cnt2", {29'b0, cnt4}, 32'h0);
    chk("t5_v2", {31'b0, ifv4}, 32'h0);

    // 6: pc wrap at the top of the address space
    b_taken = 1'b1; b_pc = 32'hFFFF_FFFC;
    tick();
    b_taken = 1'b0; lat4 = 1;
    #1;
    chk("t6_drop_noreq", {31'b0, req4}, 32'h0);
    tick();
    chk("t6_req", {31'b0, req4}, 32'h1);
    chk("t6_addr", addr4, 32'hFFFF_FFFC);
    tick();
    chk("t6_pc_wrap", pc4, 32'h0);
    chk("t6_addr_wrap", addr4, 32'h0);
    tick();
    chk("t6_no_bypass", {31'b0, ifv4}, 32'h0);
    tick();
    chk("t6_ifpc", ifpc4, 32'hFFFF_FFFC);
    chk("t6_v", {31'b0, ifv4}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
